// File: rtl/pc_hazard_ctrl.sv
// Front-end sequencer: owns the fetch PC, picks the next PC (branch redirect,
// JAL redirect, load-use hold, sequential), drives IF/ID and ID/EX stall/flush,
// and keeps saturating stall/redirect counters.
module pc_hazard_ctrl #(
  parameter int unsigned         Width    = 32,
  parameter logic [Width-1:0]    RESET_PC = '0,
  parameter int unsigned         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      id_inst,
  input  logic [Width-1:0] id_pc,
  input  logic [Width-1:0] id_imm,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_br_taken,
  input  logic [Width-1:0] ex_br_target,
  output logic [Width-1:0] pc,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  logic [Width-1:0] pc_q, pc_d;
  logic             id_valid_q, id_valid_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             use1, use2, hazard, jal;
  logic             stall_inc, flush_inc;
  logic [Width-1:0] jal_sum;

  // Only opcode and the two source fields matter here; the rest of the word is ignored.
  logic unused_inst;
  assign unused_inst = ^{id_inst[31:25], id_inst[14:7]};

  // Which source registers the ID instruction actually reads.
  always_comb begin
    use1 = 1'b0;
    use2 = 1'b0;
    case (id_inst[6:0])
      OP_R, OP_S, OP_B:      begin use1 = 1'b1; use2 = 1'b1; end
      OP_I, OP_LD, OP_JALR:  use1 = 1'b1;
      default: ;
    endcase
  end

  assign hazard = id_valid_q & ex_mem_read & (ex_rd != 5'd0) &
                  ((use1 & (ex_rd == id_inst[19:15])) |
                   (use2 & (ex_rd == id_inst[24:20])));
  assign jal     = id_valid_q & (id_inst[6:0] == OP_JAL);
  assign jal_sum = id_pc + id_imm;

  // Next-PC select and pipeline control; a taken branch squashes any wrong-path hazard/jal.
  always_comb begin
    pc_d       = pc_q + Width'(4);
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    stall      = 1'b0;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    if (ex_br_taken) begin
      pc_d       = {ex_br_target[Width-1:1], 1'b0};
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      flush_inc  = 1'b1;
    end else if (hazard) begin
      pc_d       = pc_q;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
      stall      = 1'b1;
      stall_inc  = 1'b1;
    end else if (jal) begin
      pc_d       = {jal_sum[Width-1:1], 1'b0};
      ifid_flush = 1'b1;
      flush_inc  = 1'b1;
    end
  end

  // ID-valid tracks whether IF/ID holds a real instruction rather than a bubble.
  always_comb begin
    id_valid_d = 1'b1;
    if (ifid_flush)       id_valid_d = 1'b0;
    else if (!ifid_write) id_valid_d = id_valid_q;
  end

  // PC, ID-valid and saturating counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      id_valid_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (pc_write) pc_q <= pc_d;
      id_valid_q <= id_valid_d;
      if (stall_inc && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_inc && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign pc        = pc_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
